axis_video_bridge: RTL and testbench

- Parametrised successor to the camera-pixel-to-AXI4-Stream bridge: packs CHANNELS x BPC pixel components into one stream beat.
- Buffers pixels in a DEPTH-entry FIFO and honours m_tready backpressure, so downstream stalls do not lose pixels.
- Detects overflow, discards the corrupted remainder of the frame and resynchronises on the next start-of-frame.
- Sits between the camera capture/colour-convert stage and the VDMA/video-processing AXI4-Stream slave.

---
 rtl/axis_video_pkg.sv | 21 ++
 rtl/axis_sync_fifo.sv | 73 +++++++
 rtl/axis_video_bridge.sv | 129 ++++++++++++
 tb/tb_axis_video_bridge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_video_pkg.sv
// axis_video_pkg: shared definitions for the camera-to-AXI4-Stream video bridge.
//   frame_state_t : frame tracking states (WAIT_SOF, ACTIVE, DROP)
//   BPC_DEF       : default bits per colour component
//   CHANNELS_DEF  : default components per pixel
//   level_w()     : width of a FIFO occupancy count able to hold 0..depth
package axis_video_pkg;

    localparam int BPC_DEF      = 8;
    localparam int CHANNELS_DEF = 3;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        DROP     = 2'd2
    } frame_state_t;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: synchronous first-word-fall-through FIFO with a registered
// output stage. The presented word stays counted in 'level' until it is taken.
// A write into a full FIFO is accepted when the head is read in the same cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write request (ignored when full and no read this cycle)
//   wr_data    : word to store
//   full       : level == DEPTH
//   rd_ready   : consumer accepts the presented word
//   rd_data    : presented word, registered
//   rd_valid   : rd_data holds a stored word, registered
//   level      : occupancy 0..DEPTH
module axis_sync_fifo
    import axis_video_pkg::*;
#(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    output logic                      full,
    input  logic                      rd_ready,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic [level_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic             pop;
    logic             push;
    logic [LW-1:0]    held;

    assign full        = (level == LW'(DEPTH));
    assign pop         = rd_valid && rd_ready;
    assign push        = wr_en && (!full || pop);
    assign rd_ptr_next = rd_ptr + AW'(pop);
    // Words already in storage once this cycle's read is retired; a word
    // written this cycle only becomes presentable on the following edge.
    assign held        = level - LW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr_next;
            level    <= level + LW'(push) - LW'(pop);
            rd_valid <= (held != '0);
            // Reloading the unchanged head while stalled keeps rd_data stable.
            if (held != '0) begin
                rd_data <= mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/axis_video_bridge.sv
// axis_video_bridge: packs camera pixels (CHANNELS x BPC, channel 0 in MSBs)
// into AXI4-Stream beats through a DEPTH-entry FIFO. On overflow the rest of
// the frame is discarded and the bridge resynchronises on the next sof.
//   aclk, aresetn        : clock, asynchronous active-low reset
//   i_pix/i_valid        : pixel and qualifier (no backpressure to camera)
//   i_sof/i_eol          : frame start / line end markers of the pixel
//   i_ovf_clr            : clears the sticky error flags
//   m_tdata/m_tvalid/m_tready/m_tlast/m_tuser : AXI4-Stream master
//   o_overflow           : sticky, a pixel was dropped
//   o_level              : FIFO occupancy
// Optional build macro AXIS_LINE_CHECK_EN adds a per-line pixel counter,
// forces m_tlast on the H_ACTIVE-th pixel and adds the sticky o_line_err.
module axis_video_bridge
    import axis_video_pkg::*;
#(
    parameter int BPC      = BPC_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int DEPTH    = 16,
    parameter int H_ACTIVE = 640
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [CHANNELS*BPC-1:0]    i_pix,
    input  logic                       i_valid,
    input  logic                       i_sof,
    input  logic                       i_eol,
    input  logic                       i_ovf_clr,
    output logic [CHANNELS*BPC-1:0]    m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic                       m_tuser,
    output logic                       o_overflow,
`ifdef AXIS_LINE_CHECK_EN
    output logic                       o_line_err,
`endif
    output logic [level_w(DEPTH)-1:0]  o_level
);

    localparam int W = CHANNELS * BPC;
    // A non-positive line length is a configuration error; such a build
    // accepts no pixels at all.
    localparam bit CFG_OK = (H_ACTIVE > 0);

    frame_state_t state;
    logic         full;
    logic         pop;
    logic         take;
    logic         wr;
    logic         drop;
    logic         tlast_in;
    logic [W+1:0] entry;
    logic [W+1:0] head;

    assign pop   = m_tvalid && m_tready;
    // Outside ACTIVE only a start-of-frame pixel may (re)open the stream.
    assign take  = CFG_OK && i_valid && (i_sof || state == ACTIVE);
    assign wr    = take && (!full || pop);
    assign drop  = take && full && !pop;
    assign entry = {i_sof, tlast_in, i_pix};
    assign {m_tuser, m_tlast, m_tdata} = head;

    axis_sync_fifo #(
        .WIDTH (W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (aclk),
        .rst_n    (aresetn),
        .wr_en    (wr),
        .wr_data  (entry),
        .full     (full),
        .rd_ready (m_tready),
        .rd_data  (head),
        .rd_valid (m_tvalid),
        .level    (o_level)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= WAIT_SOF;
            o_overflow <= 1'b0;
        end else begin
            if (drop) begin
                state <= DROP;
            end else if (wr) begin
                state <= ACTIVE;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                o_overflow <= 1'b0;
            end
        end
    end

`ifdef AXIS_LINE_CHECK_EN
    localparam int CW = $clog2(H_ACTIVE + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic          at_end;

    // 1-based position of the incoming pixel within its line.
    assign idx      = i_sof ? CW'(1) : cnt + CW'(1);
    assign at_end   = (idx == CW'(H_ACTIVE));
    assign tlast_in = i_eol || at_end;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt        <= '0;
            o_line_err <= 1'b0;
        end else begin
            if (wr) begin
                cnt <= tlast_in ? '0 : idx;
            end
            // Error when eol and the nominal line end disagree.
            if (wr && (i_eol != at_end)) begin
                o_line_err <= 1'b1;
            end else if (i_ovf_clr) begin
                o_line_err <= 1'b0;
            end
        end
    end
`else
    assign tlast_in = i_eol;
`endif

endmodule

// File: tb/tb_axis_video_bridge.sv
// Directed testbench for axis_video_bridge (default parameters, DEPTH=16).
module tb_axis_video_bridge;

    localparam int W  = 24;
    localparam int LW = 5;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [W-1:0]  i_pix = '0;
    logic          i_valid = 1'b0;
    logic          i_sof = 1'b0;
    logic          i_eol = 1'b0;
    logic          i_ovf_clr = 1'b0;
    logic [W-1:0]  m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          m_tuser;
    logic          o_overflow;
    logic [LW-1:0] o_level;
`ifdef AXIS_LINE_CHECK_EN
    logic          o_line_err;
`endif

    int total = 0;
    int bad   = 0;
    int maxlvl = 0;

    axis_video_bridge dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .i_pix      (i_pix),
        .i_valid    (i_valid),
        .i_sof      (i_sof),
        .i_eol      (i_eol),
        .i_ovf_clr  (i_ovf_clr),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .o_overflow (o_overflow),
`ifdef AXIS_LINE_CHECK_EN
        .o_line_err (o_line_err),
`endif
        .o_level    (o_level)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat(input logic u, input logic l, input logic [W-1:0] d);
        return {5'd0, 1'b1, u, l, d};
    endfunction

    function automatic logic [31:0] obs_beat();
        return {5'd0, m_tvalid, m_tuser, m_tlast, m_tdata};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
        if (int'(o_level) > maxlvl) maxlvl = int'(o_level);
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [W-1:0] p);
        i_valid = v;
        i_sof   = s;
        i_eol   = e;
        i_pix   = p;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tuser", 32'(m_tuser), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        aresetn = 1'b1;

        // Flow-through line of 640 pixels with tready held high
        m_tready = 1'b1;
        maxlvl = 0;
        for (int i = 0; i < 640; i++) begin
            drive(1'b1, i == 0, i == 639, 24'(32'h100000 + i));
            tick();
            if (i == 0) begin
                chk("lat_tvalid", 32'(m_tvalid), 32'd0);
                chk("lat_level", 32'(o_level), 32'd1);
            end else begin
                chk("flow_beat", obs_beat(), beat(i == 1, 1'b0, 24'(32'h100000 + i - 1)));
            end
        end
        idle();
        tick();
        chk("flow_last", obs_beat(), beat(1'b0, 1'b1, 24'(32'h100000 + 639)));
        tick();
        chk("flow_tvalid_end", 32'(m_tvalid), 32'd0);
        chk("flow_level_end", 32'(o_level), 32'd0);
        // Steady state holds the presented beat plus the pixel just written.
        chk("flow_level_max", 32'(maxlvl), 32'd2);

        // Backpressure: 16 pixels while stalled, then drain
        m_tready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, k == 0, k == 15, 24'(32'h200000 + k));
            tick();
        end
        idle();
        tick();
        tick();
        chk("bp_level", 32'(o_level), 32'd16);
        chk("bp_ovf", 32'(o_overflow), 32'd0);
        chk("bp_hold", obs_beat(), beat(1'b1, 1'b0, 24'h200000));
        m_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("bp_beat", obs_beat(), beat(k == 0, k == 15, 24'(32'h200000 + k)));
            tick();
        end
        chk("bp_tvalid_end", 32'(m_tvalid), 32'd0);
        chk("bp_level_end", 32'(o_level), 32'd0);

        // Full FIFO with a read and a write in the same cycle
        m_tready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, k == 0, 1'b0, 24'(32'h300000 + k));
            tick();
        end
        idle();
        tick();
        chk("full_level", 32'(o_level), 32'd16);
        drive(1'b1, 1'b0, 1'b0, 24'h300010);
        m_tready = 1'b1;
        tick();
        idle();
        chk("full_rw_level", 32'(o_level), 32'd16);
        chk("full_rw_ovf", 32'(o_overflow), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            chk("full_rw_beat", obs_beat(), beat(1'b0, 1'b0, 24'(32'h300000 + k)));
            tick();
        end
        chk("full_rw_level_end", 32'(o_level), 32'd0);

        // Overflow: 17 pixels while stalled
        m_tready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, k == 0, 1'b0, 24'(32'h400000 + k));
            tick();
        end
        chk("ovf_set", 32'(o_overflow), 32'd1);
        chk("ovf_level", 32'(o_level), 32'd16);
        // Drain while non-sof pixels keep arriving; they must be discarded
        m_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b0, 1'b0, 24'(32'h4F0000 + k));
            chk("ovf_drain", obs_beat(), beat(k == 0, 1'b0, 24'(32'h400000 + k)));
            tick();
        end
        chk("ovf_discard_level", 32'(o_level), 32'd0);
        chk("ovf_discard_tvalid", 32'(m_tvalid), 32'd0);
        // Next frame is delivered intact
        drive(1'b1, 1'b1, 1'b0, 24'h500000);
        tick();
        chk("resync_level", 32'(o_level), 32'd1);
        drive(1'b1, 1'b0, 1'b1, 24'h500001);
        tick();
        chk("resync_beat0", obs_beat(), beat(1'b1, 1'b0, 24'h500000));
        idle();
        tick();
        chk("resync_beat1", obs_beat(), beat(1'b0, 1'b1, 24'h500001));
        tick();
        chk("ovf_sticky", 32'(o_overflow), 32'd1);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("ovf_clr", 32'(o_overflow), 32'd0);

        // Asynchronous reset mid-line with 9 pixels buffered
        m_tready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, k == 0, 1'b0, 24'(32'h600000 + k));
            tick();
        end
        chk("arst_pre_level", 32'(o_level), 32'd9);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_level", 32'(o_level), 32'd0);
        chk("arst_tvalid", 32'(m_tvalid), 32'd0);
        chk("arst_tdata", 32'(m_tdata), 32'd0);
        chk("arst_tuser", 32'(m_tuser), 32'd0);
        idle();
        @(negedge aclk);
        aresetn = 1'b1;
        m_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 24'(32'h700000 + k));
            tick();
        end
        chk("arst_ignore_level", 32'(o_level), 32'd0);
        chk("arst_ignore_tvalid", 32'(m_tvalid), 32'd0);
        // One-pixel line: sof and eol on the same pixel
        drive(1'b1, 1'b1, 1'b1, 24'h800000);
        tick();
        idle();
        tick();
        chk("one_px_line", obs_beat(), beat(1'b1, 1'b1, 24'h800000));
        tick();
        chk("one_px_end", 32'(m_tvalid), 32'd0);

`ifdef AXIS_LINE_CHECK_EN
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("lc_clr", 32'(o_line_err), 32'd0);
        // Short line: eol on the 3rd pixel
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, k == 0, k == 2, 24'(32'h900000 + k));
            tick();
        end
        idle();
        tick();
        tick();
        chk("lc_short", 32'(o_line_err), 32'd1);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("lc_clr2", 32'(o_line_err), 32'd0);
        // Long line without eol: tlast forced on the 640th pixel
        for (int i = 0; i < 641; i++) begin
            drive(1'b1, i == 0, 1'b0, 24'(32'hA00000 + i));
            tick();
            if (i >= 1) begin
                chk("lc_beat", obs_beat(), beat(i == 1, i == 640, 24'(32'hA00000 + i - 1)));
            end
        end
        idle();
        tick();
        chk("lc_after", obs_beat(), beat(1'b0, 1'b0, 24'(32'hA00000 + 640)));
        chk("lc_long_err", 32'(o_line_err), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
